// File: rtl/time_pkg.sv
// time_pkg: shared BCD constants, data_out field slices, mode type and BCD step helper
//   Used by bcd2_counter and bcd_time_counter (optional feature macro AUTO_REPEAT_EN lives in the top).
package time_pkg;
    localparam logic [7:0]  HOUR_MIN   = 8'h01;
    localparam logic [7:0]  HOUR_MAX   = 8'h12;
    localparam logic [7:0]  HOUR_ROLL  = 8'h11;
    localparam logic [7:0]  MINSEC_MAX = 8'h59;
    localparam logic [23:0] RESET_TIME = 24'h120000;
    localparam int HR_MSB = 23;
    localparam int HR_LSB = 16;
    localparam int MN_MSB = 15;
    localparam int MN_LSB = 8;
    localparam int SC_MSB = 7;
    localparam int SC_LSB = 0;
    typedef enum logic [1:0] {MODE_RUN, MODE_MIN, MODE_HOUR} mode_t;
    // Digit-wise increment: the units digit rolls 9 -> 0 into the tens digit, never binary carry.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max_v,
                                            input logic [7:0] min_v);
        bcd_next = (v == max_v) ? min_v :
                   (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD register that wraps from MAX_VAL to MIN_VAL
//   clock, reset : clock, synchronous active-high reset (loads RST_VAL)
//   inc          : advance one step
//   clr          : load MIN_VAL (wins over inc)
//   value        : current BCD value
//   carry        : inc while at MAX_VAL (the wrap step)
module bcd2_counter
    import time_pkg::*;
#(
    parameter logic [7:0] MIN_VAL = 8'h00,
    parameter logic [7:0] MAX_VAL = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);
    always_ff @(posedge clock)
        if (reset) value <= RST_VAL;
        else if (clr) value <= MIN_VAL;
        else if (inc) value <= bcd_next(value, MAX_VAL, MIN_VAL);
    assign carry = inc & (value == MAX_VAL);
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 12-hour BCD hh:mm:ss timekeeper with hour/minute set modes
//   clock, reset : clock, synchronous active-high reset (12:00:00)
//   tick_1hz     : one-cycle per-second enable
//   set_ore      : hour-set mode (priority over set_min)
//   set_min      : minute-set mode
//   inc          : button level; rising edge increments the field being set
//   data_out     : {hours, minutes, seconds} BCD
//   set_ore_out  : registered set_ore, aligned with data_out
//   roll_12      : one-cycle pulse after a counted 11:59:59 -> 12:00:00
//   Macro AUTO_REPEAT_EN adds hold-to-repeat after REPEAT_DLY ticks.
module bcd_time_counter
    import time_pkg::*;
#(
    parameter int REPEAT_DLY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        set_ore,
    input  logic        set_min,
    input  logic        inc,
    output logic [23:0] data_out,
    output logic        set_ore_out,
    output logic        roll_12
);
    mode_t mode;
    logic inc_q, inc_edge, step, rpt_fire;
    logic sec_carry, min_carry, hr_wrap, sec_clr, min_inc, hr_inc;
    logic [7:0] sec, min, hr;
    always_comb mode = set_ore ? MODE_HOUR : set_min ? MODE_MIN : MODE_RUN;
    assign inc_edge = inc & ~inc_q;
    assign step     = inc_edge | rpt_fire;
    assign sec_clr  = (mode == MODE_MIN) & step;
    assign min_inc  = sec_carry | sec_clr;
    // sec_carry only fires in run mode, so a minute-set wrap never reaches hours
    assign hr_inc   = (sec_carry & min_carry) | ((mode == MODE_HOUR) & step);
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 2);
    logic [RW-1:0] rpt_cnt;
    mode_t mode_q;
    logic rpt_hold;
    // Holding only counts while the same set mode stays active with inc high
    assign rpt_hold = inc & (mode != MODE_RUN) & (mode == mode_q);
    assign rpt_fire = rpt_hold & tick_1hz & (rpt_cnt == RW'(REPEAT_DLY));
    always_ff @(posedge clock)
        if (reset) begin
            rpt_cnt <= '0;
            mode_q  <= MODE_RUN;
        end else begin
            mode_q <= mode;
            if (!rpt_hold) rpt_cnt <= '0;
            else if (tick_1hz && !rpt_fire) rpt_cnt <= rpt_cnt + 1'b1;
        end
`else
    // No repeat path: only rising edges increment; REPEAT_DLY stays in the interface.
    assign rpt_fire = REPEAT_DLY < 0;
`endif
    bcd2_counter #(.MIN_VAL(8'h00), .MAX_VAL(MINSEC_MAX), .RST_VAL(RESET_TIME[SC_MSB:SC_LSB])) u_sec (
        .clock(clock), .reset(reset), .inc((mode == MODE_RUN) & tick_1hz), .clr(sec_clr),
        .value(sec), .carry(sec_carry)
    );
    bcd2_counter #(.MIN_VAL(8'h00), .MAX_VAL(MINSEC_MAX), .RST_VAL(RESET_TIME[MN_MSB:MN_LSB])) u_min (
        .clock(clock), .reset(reset), .inc(min_inc), .clr(1'b0),
        .value(min), .carry(min_carry)
    );
    bcd2_counter #(.MIN_VAL(HOUR_MIN), .MAX_VAL(HOUR_MAX), .RST_VAL(RESET_TIME[HR_MSB:HR_LSB])) u_hr (
        .clock(clock), .reset(reset), .inc(hr_inc), .clr(1'b0),
        .value(hr), .carry(hr_wrap)
    );
    always_ff @(posedge clock)
        if (reset) begin
            inc_q       <= 1'b0;
            set_ore_out <= 1'b0;
            roll_12     <= 1'b0;
        end else begin
            inc_q       <= inc;
            set_ore_out <= set_ore;
            // Only the counted 11 -> 12 hour step pulses; the 12 -> 01 wrap does not
            roll_12     <= sec_carry & min_carry & ~hr_wrap & (hr == HOUR_ROLL);
        end
    assign data_out[HR_MSB:HR_LSB] = hr;
    assign data_out[MN_MSB:MN_LSB] = min;
    assign data_out[SC_MSB:SC_LSB] = sec;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: scoreboard bench comparing bcd_time_counter with an integer time model
module tb_bcd_time_counter;
    localparam int RD = 2;
    logic clock = 1'b0;
    logic reset = 1'b1, tick_1hz = 1'b0, set_ore = 1'b0, set_min = 1'b0, inc = 1'b0;
    logic [23:0] data_out;
    logic set_ore_out, roll_12;
    int checks = 0, failures = 0;
    logic [25:0] exp_q[$];
    logic [25:0] mon_e;
    int h = 12, m = 0, s = 0, cnt = 0, pmode = 0;
    bit pinc = 0, pso = 0;

    always #5 clock = ~clock;

    bcd_time_counter #(.REPEAT_DLY(RD)) dut (
        .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .set_ore(set_ore),
        .set_min(set_min), .inc(inc), .data_out(data_out), .set_ore_out(set_ore_out),
        .roll_12(roll_12)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    // Drive one cycle of inputs and push the state the model says follows that clock edge
    task automatic drive(input bit r, input bit t, input bit so, input bit sm, input bit i);
        bit e, fire, roll;
        int md;
        @(negedge clock);
        reset = r; tick_1hz = t; set_ore = so; set_min = sm; inc = i;
        roll = 0;
        fire = 0;
        if (r) begin
            h = 12; m = 0; s = 0; cnt = 0; pmode = 0; pinc = 0; pso = 0;
        end else begin
            md = so ? 2 : sm ? 1 : 0;
            e = i && !pinc;
`ifdef AUTO_REPEAT_EN
            if (!i || md != pmode || md == 0) cnt = 0;
            else if (t) begin
                if (cnt == RD) fire = 1;
                else cnt++;
            end
`endif
            if (md == 0 && t) begin
                roll = (h == 11 && m == 59 && s == 59);
                s++;
                if (s == 60) begin
                    s = 0;
                    m++;
                    if (m == 60) begin
                        m = 0;
                        h = h % 12 + 1;
                    end
                end
            end else if (md == 2 && (e || fire)) h = h % 12 + 1;
            else if (md == 1 && (e || fire)) begin
                m = (m + 1) % 60;
                s = 0;
            end
            pinc = i; pmode = md; pso = so;
        end
        exp_q.push_back({bcd(h), bcd(m), bcd(s), pso, roll});
    endtask

    task automatic pulse(input bit so, input bit sm, input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, so, sm, 1);
            drive(0, 0, so, sm, 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) drive(0, 1, 0, 0, 0);
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (data_out !== mon_e[25:2]) begin
                failures++;
                $display("FAIL data_out got=%h exp=%h t=%0t", data_out, mon_e[25:2], $time);
            end
            checks++;
            if (set_ore_out !== mon_e[1]) begin
                failures++;
                $display("FAIL set_ore_out got=%b exp=%b t=%0t", set_ore_out, mon_e[1], $time);
            end
            checks++;
            if (roll_12 !== mon_e[0]) begin
                failures++;
                $display("FAIL roll_12 got=%b exp=%b t=%0t", roll_12, mon_e[0], $time);
            end
        end
    end

    initial begin
        bit so, sm, i;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        ticks(1);
        drive(0, 0, 0, 0, 0);
        pulse(1, 0, 11);
        pulse(0, 1, 59);
        ticks(59);
        ticks(1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        ticks(3600);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 1, 0, 1);
            drive(0, 1, 1, 0, 0);
        end
        pulse(1, 0, 10);
        pulse(0, 1, 59);
        ticks(37);
        drive(0, 0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 1, 1);
            drive(0, 0, 0, 1, 1);
        end
        drive(0, 0, 0, 1, 0);
        ticks(3);
        drive(0, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0);
        pulse(1, 0, 1);
        drive(0, 0, 1, 0, 1);
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 1, 0, 1);
            drive(0, 0, 1, 0, 1);
        end
        drive(0, 0, 1, 0, 0);
        so = 0; sm = 0; i = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) so = ~so;
            if ($urandom_range(0, 15) == 0) sm = ~sm;
            if ($urandom_range(0, 2) == 0) i = ~i;
            drive($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)), so, sm, i);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
